// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared codes, enums and helpers for the rock-paper-scissors remote player
package rps_pkg;

    typedef enum logic [1:0] {
        CH_NONE     = 2'd0,
        CH_ROCK     = 2'd1,
        CH_PAPER    = 2'd2,
        CH_SCISSORS = 2'd3
    } choice_e;

    localparam logic [2:0] CODE_IDLE          = 3'd7;
    localparam logic [2:0] CODE_PERSON_WINS   = 3'd1;
    localparam logic [2:0] CODE_COMPUTER_WINS = 3'd2;
    localparam logic [2:0] CODE_TIE           = 3'd4;

    typedef enum logic [1:0] {
        RES_REMOTE_WIN  = 2'd0,
        RES_REMOTE_LOSS = 2'd1,
        RES_TIE         = 2'd2
    } result_e;

    typedef enum logic [1:0] {
        ERR_ILLEGAL_CHOICE = 2'd0,
        ERR_BAD_CODE       = 2'd1,
        ERR_RESULT_TO      = 2'd2,
        ERR_IDLE_TO        = 2'd3
    } err_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS       = 3'd1,
        ST_WAIT_RESULT = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_WAIT_IDLE   = 3'd4
    } state_e;

    // Active-low {rock,paper,scissors} pattern for a legal choice; all high otherwise.
    function automatic logic [2:0] choice_lines(input logic [1:0] c);
        case (c)
            CH_ROCK:     return 3'b011;
            CH_PAPER:    return 3'b101;
            CH_SCISSORS: return 3'b110;
            default:     return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/rps_code_filter.sv
// rtl/rps_code_filter.sv - synchronizer and stability filter for the board result code
module rps_code_filter
    import rps_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    output logic [2:0] fcode,
    output logic       stable
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

    logic [2:0]    sync_q [SYNC_STAGES];
    logic [2:0]    sync_out;
    logic [2:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign stable   = (cnt == CNT_FULL);

    // Count consecutive equal synced samples; any change restarts at one.
    always_comb begin
        cnt_next = CW'(1);
        if (sync_out == cand)
            cnt_next = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= CODE_IDLE;
            cand  <= CODE_IDLE;
            cnt   <= '0;
            fcode <= CODE_IDLE;
        end else begin
            sync_q[0] <= code;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            cand <= sync_out;
            cnt  <= cnt_next;
            if (cnt_next == CNT_FULL)
                fcode <= sync_out;
        end
    end

endmodule

// File: rtl/rps_remote_player.sv
// rtl/rps_remote_player.sv - remote-player initiator: drives choice lines, decodes and tallies results
module rps_remote_player
    import rps_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int RESULT_TIMEOUT = 1024,
    parameter int IDLE_TIMEOUT   = 2**28,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             choice_valid,
    input  logic [1:0]       choice,
    output logic             choice_ready,
    output logic [2:0]       choice_n,
    input  logic [2:0]       result_code,
    input  logic             clear_scores,
    output logic             result_valid,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses,
    output logic [CNT_W-1:0] ties,
    output logic             err,
    output logic [1:0]       err_kind
);

    localparam logic [31:0]      RES_LOAD  = 32'(RESULT_TIMEOUT - 1);
    localparam logic [31:0]      IDLE_LOAD = 32'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e      state;
    logic [31:0] tmo;
    logic [2:0]  fcode;
    logic        fstable;

    rps_code_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .code   (result_code),
        .fcode  (fcode),
        .stable (fstable)
    );

    // Ready only once the filter has confirmed the board is idle.
    assign choice_ready = (state == ST_IDLE) && fstable && (fcode == CODE_IDLE);

    // A clear in the same cycle as a result leaves the counter at one.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (clear_scores)
            return CNT_W'(1);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            choice_n     <= 3'b111;
            tmo          <= '0;
            result_valid <= 1'b0;
            result       <= 2'd0;
            err          <= 1'b0;
            err_kind     <= 2'd0;
            wins         <= '0;
            losses       <= '0;
            ties         <= '0;
        end else begin
            result_valid <= 1'b0;
            err          <= 1'b0;
            if (clear_scores) begin
                wins   <= '0;
                losses <= '0;
                ties   <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (choice_valid && choice_ready) begin
                        if (choice == CH_NONE) begin
                            err      <= 1'b1;
                            err_kind <= ERR_ILLEGAL_CHOICE;
                        end else begin
                            choice_n <= choice_lines(choice);
                            state    <= ST_PRESS;
                        end
                    end
                end
                ST_PRESS: begin
                    tmo   <= RES_LOAD;
                    state <= ST_WAIT_RESULT;
                end
                ST_WAIT_RESULT: begin
                    if (fcode == CODE_IDLE) begin
                        if (tmo == '0) begin
                            err      <= 1'b1;
                            err_kind <= ERR_RESULT_TO;
                            choice_n <= 3'b111;
                            state    <= ST_RELEASE;
                        end else begin
                            tmo <= tmo - 32'd1;
                        end
                    end else begin
                        choice_n <= 3'b111;
                        state    <= ST_RELEASE;
                        case (fcode)
                            CODE_PERSON_WINS: begin
                                result_valid <= 1'b1;
                                result       <= RES_REMOTE_WIN;
                                wins         <= bump(wins);
                            end
                            CODE_COMPUTER_WINS: begin
                                result_valid <= 1'b1;
                                result       <= RES_REMOTE_LOSS;
                                losses       <= bump(losses);
                            end
                            CODE_TIE: begin
                                result_valid <= 1'b1;
                                result       <= RES_TIE;
                                ties         <= bump(ties);
                            end
                            default: begin
                                err      <= 1'b1;
                                err_kind <= ERR_BAD_CODE;
                            end
                        endcase
                    end
                end
                ST_RELEASE: begin
                    tmo   <= IDLE_LOAD;
                    state <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (fcode == CODE_IDLE) begin
                        state <= ST_IDLE;
                    end else if (tmo == '0) begin
                        err      <= 1'b1;
                        err_kind <= ERR_IDLE_TO;
                        state    <= ST_IDLE;
                    end else begin
                        tmo <= tmo - 32'd1;
                    end
                end
                default: begin
                    choice_n <= 3'b111;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rps_remote_player.sv
// tb/tb_rps_remote_player.sv - directed self-checking bench for rps_remote_player
module tb_rps_remote_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       choice_valid;
    logic [1:0] choice;
    logic       choice_ready;
    logic [2:0] choice_n;
    logic [2:0] result_code;
    logic       clear_scores;
    logic       result_valid;
    logic [1:0] result;
    logic [7:0] wins, losses, ties;
    logic       err;
    logic [1:0] err_kind;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    rps_remote_player #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (4),
        .RESULT_TIMEOUT (1024),
        .IDLE_TIMEOUT   (256),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .choice_valid (choice_valid),
        .choice       (choice),
        .choice_ready (choice_ready),
        .choice_n     (choice_n),
        .result_code  (result_code),
        .clear_scores (clear_scores),
        .result_valid (result_valid),
        .result       (result),
        .wins         (wins),
        .losses       (losses),
        .ties         (ties),
        .err          (err),
        .err_kind     (err_kind)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (choice_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", {31'd0, choice_ready}, 1);
    endtask

    task automatic offer(input logic [1:0] ch);
        wait_ready();
        choice_valid = 1'b1;
        choice       = ch;
        @(negedge clk);
        choice_valid = 1'b0;
        choice       = 2'd0;
    endtask

    task automatic wait_event(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (result_valid !== 1'b1 && err !== 1'b1 && cnt < limit);
    endtask

    task automatic play(input logic [1:0] ch, input logic [2:0] code, input int delay,
                        input logic [2:0] exp_lines, input logic [1:0] exp_res, input bit verbose);
        int k;
        offer(ch);
        if (verbose) check("lines_low", {29'd0, choice_n}, {29'd0, exp_lines});
        repeat (delay) @(negedge clk);
        result_code = code;
        wait_event(100, k);
        check("result_valid", {31'd0, result_valid}, 1);
        check("result", {30'd0, result}, {30'd0, exp_res});
        if (verbose) check("latency", k, 7);
        result_code = 3'd7;
    endtask

    initial begin
        rst          = 1'b1;
        choice_valid = 1'b0;
        choice       = 2'd0;
        result_code  = 3'd7;
        clear_scores = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_lines", {29'd0, choice_n}, 3'b111);
        check("rst_ready", {31'd0, choice_ready}, 0);
        check("rst_rv", {31'd0, result_valid}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_wins", {24'd0, wins}, 0);

        // rock wins
        play(2'd1, 3'd1, 10, 3'b011, 2'd0, 1'b1);
        check("t1_wins", {24'd0, wins}, 1);
        repeat (2) @(negedge clk);
        check("t1_release", {29'd0, choice_n}, 3'b111);

        // paper loses, then ties
        play(2'd2, 3'd2, 10, 3'b101, 2'd1, 1'b1);
        check("t2_losses", {24'd0, losses}, 1);
        play(2'd2, 3'd4, 10, 3'b101, 2'd2, 1'b1);
        check("t2_ties", {24'd0, ties}, 1);

        // glitch shorter than the stability window is ignored
        offer(2'd3);
        check("t3_lines", {29'd0, choice_n}, 3'b110);
        repeat (5) @(negedge clk);
        result_code = 3'd1;
        repeat (3) @(negedge clk);
        result_code = 3'd7;
        wait_event(20, n);
        check("t3_no_result", {31'd0, result_valid}, 0);
        check("t3_no_err", {31'd0, err}, 0);
        result_code = 3'd4;
        wait_event(100, n);
        check("t3_rv", {31'd0, result_valid}, 1);
        check("t3_tie", {30'd0, result}, 2);
        check("t3_ties", {24'd0, ties}, 2);
        result_code = 3'd7;

        // no answer: result timeout
        offer(2'd1);
        wait_event(1100, n);
        check("t4_err", {31'd0, err}, 1);
        check("t4_kind", {30'd0, err_kind}, 2);
        check("t4_to_cycles", n, 1025);
        check("t4_lines", {29'd0, choice_n}, 3'b111);
        check("t4_counts", {8'd0, wins, losses, ties}, {8'd0, 8'd1, 8'd1, 8'd2});

        // bad code
        offer(2'd2);
        result_code = 3'd5;
        wait_event(100, n);
        check("t4b_err", {31'd0, err}, 1);
        check("t4b_kind", {30'd0, err_kind}, 1);
        result_code = 3'd7;

        // illegal choice
        wait_ready();
        choice_valid = 1'b1;
        choice       = 2'd0;
        @(negedge clk);
        choice_valid = 1'b0;
        check("t5_err", {31'd0, err}, 1);
        check("t5_kind", {30'd0, err_kind}, 0);
        check("t5_lines", {29'd0, choice_n}, 3'b111);
        @(negedge clk);
        check("t5_err_pulse", {31'd0, err}, 0);

        // board stuck on a result: idle timeout, ready held off
        offer(2'd1);
        result_code = 3'd1;
        wait_event(100, n);
        check("t5_win", {30'd0, result}, 0);
        check("t5_wins", {24'd0, wins}, 2);
        wait_event(300, n);
        check("t5_idle_err", {31'd0, err}, 1);
        check("t5_idle_kind", {30'd0, err_kind}, 3);
        repeat (3) @(negedge clk);
        check("t5_ready_blocked", {31'd0, choice_ready}, 0);
        result_code = 3'd7;

        // reset mid-round
        offer(2'd1);
        @(negedge clk);
        check("t6_rock_low", {29'd0, choice_n}, 3'b011);
        rst = 1'b1;
        #1;
        check("t6_rst_lines", {29'd0, choice_n}, 3'b111);
        check("t6_rst_counts", {8'd0, wins, losses, ties}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_ready", {31'd0, choice_ready}, 0);

        // saturation
        for (int i = 0; i < 255; i++)
            play(2'd1, 3'd1, 0, 3'b011, 2'd0, 1'b0);
        check("t6_wins_255", {24'd0, wins}, 255);
        play(2'd1, 3'd1, 0, 3'b011, 2'd0, 1'b0);
        check("t6_wins_sat", {24'd0, wins}, 255);

        // clear together with a win
        offer(2'd1);
        clear_scores = 1'b1;
        result_code  = 3'd1;
        wait_event(100, n);
        clear_scores = 1'b0;
        check("t6_clr_rv", {31'd0, result_valid}, 1);
        check("t6_clr_wins", {24'd0, wins}, 1);
        result_code = 3'd7;
        @(negedge clk);
        check("t6_clr_wins_hold", {24'd0, wins}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
